toggle_cdc_merge_rx: RTL
========================

Name: toggle_cdc_merge_rx

Overview:
Destination-domain receiver for toggle-signalled crossings from CHANNELS independent source channels. Each channel synchronises its toggle and detects a change on it. On a change it captures that channel's data word. A round-robin arbiter then merges all channels onto a single valid/ready stream. Each accepted word returns a per-channel ack toggle to the source. Sits between the UART-domain producers and the FIFO write side, and adds an overrun flag for each channel.

Parameters:
CHANNELS, 4, number of toggle/data source channels (1..16)
DATA_W, 8, data bits per channel
SYNC_STAGES, 2, synchroniser flops per toggle (legal range 2..4; elaboration error outside it)
CHAN_W, $clog2(CHANNELS) min 1, derived width of out_chan

Ports:
clk  in  1  destination clock
rst  in  1  reset, asynchronous, active-high
toggle_in  in  CHANNELS  per-channel request toggle from the source domain
data_in  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]; held stable by the source while toggle_in[c] != ack_out[c]
ack_out  out  CHANNELS  per-channel acknowledge toggle back to the source
edge_pulse  out  CHANNELS  raw one-cycle detect pulse per channel
out_valid  out  1  merged stream valid
out_ready  in  1  merged stream ready
out_data  out  DATA_W  data of the selected channel
out_chan  out  CHAN_W  index of the selected channel
overrun  out  CHANNELS  sticky per-channel overrun flags
ovr_clr  in  CHANNELS  per-channel overrun clear, one bit per channel

Behaviour:
- Reset values: all sync flops, edge-history flops, pending, hold registers and ack_out = 0. overrun = 0. Round-robin pointer = 0. Outputs therefore reset to out_valid=0, out_data=0, out_chan=0, edge_pulse=0.
- Synchroniser: an SYNC_STAGES-deep flop chain per channel, followed by one history flop.
- Edge detect: edge_pulse[c] = last_sync ^ history, combinational, high for exactly one cycle per toggle change. Both rising and falling changes count.
- Detect latency: toggle_in changes and is sampled at edge E1. edge_pulse is high in the cycle after edge E(SYNC_STAGES).
- Capture: at the edge where edge_pulse[c]=1, hold[c] <= data_in[c] and pending[c] <= 1.
- Arbiter is combinational over the pending registers:
  - out_valid = |pending.
  - Selection is the first pending channel at or after the rr pointer, wrapping modulo CHANNELS.
  - out_chan and out_data come from the selected channel. With out_valid=0 they equal the last selection and carry no meaning.
- Transfer on out_valid & out_ready at a clk edge:
  - pending[sel] <= 0.
  - ack_out[sel] <= ~ack_out[sel].
  - rr pointer <= (sel+1) mod CHANNELS.
  - The pointer does not move when no transfer happens.
- Hold rule: out_valid, out_data and out_chan stay stable while out_valid=1 and out_ready=0, unless a higher-priority channel (relative to the unchanged pointer) becomes pending. Selection may change only on such a newly pending channel.
- Edge and transfer in the same cycle on the same channel: the new edge wins. pending stays 1, hold takes the new data_in, ack still toggles, and no overrun is raised.
- Overrun: edge_pulse[c]=1 while pending[c]=1 and channel c is not being transferred this cycle. Then overrun[c] <= 1, hold[c] and pending stay unchanged, and the new word is dropped.
- ovr_clr[c] clears overrun[c] at the next edge. If a new overrun occurs in the same cycle as ovr_clr, the set wins.
- Async reset mid-operation: all state returns to reset values immediately and pending words are lost. Source and destination domains must be reset together. A toggle_in that is nonzero after reset is detected as a real change.
- CHANNELS=1: the arbiter degenerates, out_chan=0, and the pointer is constant 0.
- No combinational path from toggle_in or data_in to any output. out_ready reaches only pending and ack (registered).

Decomposition:
- Shared package (cdc_pkg): SYNC_STAGES legal-range constants, and a function computing CHAN_W with a minimum of 1.
- One natural sub-module: toggle_sync_detect_n. It is a per-channel SYNC_STAGES synchroniser plus history flop producing edge_pulse, and is instantiated CHANNELS times by generate.
- The arbiter stays inline (rotate, priority-find, unrotate).

Test Plan:
- Single channel, CHANNELS=4, SYNC_STAGES=2: toggle_in[2] 0->1 with data 0xA5, out_ready=1. Expect edge_pulse[2] for one cycle after the 2nd sampling edge, then out_valid with out_chan=2 and out_data=0xA5. ack_out[2] reaches 1 one cycle after the transfer, and overrun stays 0.
- Round robin: channels 0, 1 and 3 toggle in the same cycle with data 0x10/0x11/0x13, out_ready=1. Expect transfers in order chan 0, 1, 3 on consecutive cycles. Then channels 0 and 3 again with the pointer at 0 give order 0, 3.
- Backpressure: out_ready=0 for 10 cycles with channel 1 pending. Expect out_valid/out_chan=1/out_data stable throughout. On release, exactly one transfer and one ack_out[1] toggle.
- Overrun: hold out_ready=0 and toggle channel 0 twice (0x01 then 0x02). Expect overrun[0]=1 and out_data stays 0x01. Pulsing ovr_clr[0] clears it; clear coinciding with a third edge leaves it set.
- Edge-with-transfer: time a toggle so the detect lands in the same cycle as channel 0's accept. Expect pending stays 1 with the new data, no overrun, and ack toggled once.
- Reset mid-operation: assert rst with two channels pending. Expect all outputs 0 asynchronously. After release, sweep SYNC_STAGES=3,4 and check that detect latency equals SYNC_STAGES edges.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the toggle-CDC receiver slice.
//   SYNC_STAGES_MIN/MAX : legal synchroniser depth range
//   chan_w(n)           : channel-index width, never narrower than 1 bit
package cdc_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/toggle_sync_detect_n.sv
// Per-channel toggle synchroniser with change detect.
//   clk, rst   : destination clock, async active-high reset
//   toggle_i   : source-domain toggle (asynchronous)
//   edge_o     : one-cycle pulse on every synchronised toggle change
module toggle_sync_detect_n #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/toggle_cdc_merge_rx.sv
// Destination-side receiver merging CHANNELS toggle-signalled crossings
// onto one valid/ready stream with round-robin arbitration.
//   toggle_in/data_in   : per-channel request toggle and word from the source
//   ack_out             : per-channel acknowledge toggle back to the source
//   edge_pulse          : raw per-channel detect pulse
//   out_valid/ready/data/chan : merged output stream
//   overrun/ovr_clr     : sticky per-channel dropped-word flags and clears
module toggle_cdc_merge_rx
    import cdc_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CHAN_W      = chan_w(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        toggle_in,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    output logic [CHANNELS-1:0]        ack_out,
    output logic [CHANNELS-1:0]        edge_pulse,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CHAN_W-1:0]          out_chan,
    output logic [CHANNELS-1:0]        overrun,
    input  logic [CHANNELS-1:0]        ovr_clr
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("toggle_cdc_merge_rx: SYNC_STAGES must be within 2..4");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_chan
        $error("toggle_cdc_merge_rx: CHANNELS must be within 1..16");
    end

    localparam logic [CHAN_W:0] CH_N = (CHAN_W+1)'(CHANNELS);

    logic [CHANNELS-1:0]   pending_q, pending_d;
    logic [CHANNELS-1:0]   ack_q, ack_d;
    logic [CHANNELS-1:0]   ovr_q, ovr_d;
    logic [DATA_W-1:0]     hold_q [CHANNELS];
    logic [DATA_W-1:0]     hold_d [CHANNELS];
    logic [CHAN_W-1:0]     rr_q, rr_d;
    logic [CHAN_W-1:0]     last_q, last_d;

    logic [2*CHANNELS-1:0] pend_dbl;
    logic [CHANNELS-1:0]   rot;
    logic [CHAN_W-1:0]     off;
    logic [CHAN_W-1:0]     sel;
    logic [CHAN_W:0]       sum;
    logic [CHAN_W:0]       nxt;
    logic                  found;
    logic                  xfer;
    logic [CHANNELS-1:0]   take;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
        toggle_sync_detect_n #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .rst      (rst),
            .toggle_i (toggle_in[c]),
            .edge_o   (edge_pulse[c])
        );
    end

    // Rotate pending so the pointer lands on bit 0, find the lowest set bit,
    // then add the pointer back modulo CHANNELS.
    always_comb begin
        pend_dbl = {pending_q, pending_q} >> rr_q;
        rot      = pend_dbl[CHANNELS-1:0];
        found    = 1'b0;
        off      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = CHAN_W'(i);
            end
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= CH_N) sum = sum - CH_N;
        // Idle output keeps the previous selection so out_data/out_chan do not churn.
        sel    = found ? sum[CHAN_W-1:0] : last_q;
        last_d = sel;

        xfer = found & out_ready;
        nxt  = {1'b0, sel} + (CHAN_W+1)'(1);
        if (nxt >= CH_N) nxt = '0;
        rr_d = xfer ? nxt[CHAN_W-1:0] : rr_q;
    end

    always_comb begin
        out_data = '0;
        take     = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (sel == CHAN_W'(c)) begin
                out_data = hold_q[c];
                take[c]  = xfer;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        ack_d     = ack_q;
        ovr_d     = ovr_q;
        hold_d    = hold_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            // A detect coinciding with this channel's accept refills the slot.
            if (edge_pulse[c] && (!pending_q[c] || take[c])) begin
                hold_d[c]    = data_in[c*DATA_W +: DATA_W];
                pending_d[c] = 1'b1;
            end else if (take[c]) begin
                pending_d[c] = 1'b0;
            end
            if (take[c]) ack_d[c] = ~ack_q[c];
            if (edge_pulse[c] && pending_q[c] && !take[c]) begin
                ovr_d[c] = 1'b1;
            end else if (ovr_clr[c]) begin
                ovr_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            ack_q     <= '0;
            ovr_q     <= '0;
            rr_q      <= '0;
            last_q    <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_d;
            ovr_q     <= ovr_d;
            rr_q      <= rr_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    assign out_valid = found;
    assign out_chan  = sel;
    assign ack_out   = ack_q;
    assign overrun   = ovr_q;

endmodule
